pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central sequencer for the 5-stage Beta pipeline. Observes decode-stage op flags, zero flag,
//  operand-hazard stall, illegal-opcode and interrupt inputs. Drives PC mux select, PC write
//  enable and IR-source selects for the fetch, decode and execute boundaries.
//  Handles branch/jump redirect, reset sequencing, and exception/interrupt injection with holdoff.
// PARAMETERS
//  IRQ_HOLDOFF  3  cycles after an injected exception during which irq is ignored (>=1)
//  CNT_W        2  width of holdoff counter; must hold IRQ_HOLDOFF
// PORTS
//  clk          in   1  clock
//  rst          in   1  synchronous reset, active-high
//  stall        in   1  decode operand hazard (load-use), from register file
//  op_jmp       in   1  JMP in decode
//  op_beq       in   1  BEQ in decode
//  op_bne       in   1  BNE in decode
//  zr           in   1  decode RA operand == 0
//  illop_dec    in   1  unimplemented opcode in decode
//  irq          in   1  level interrupt request
//  kernel_mode  in   1  PC[31] of decode instruction; masks irq
//  pc_sel       out  3  PC mux: INC=0 BR=1 JMP=2 ILLOP=3 XADDR=4 RESET=5
//  pc_we        out  1  PC register load enable
//  ir_src_if    out  2  IR source, fetch->decode (`IR_SRC_DATA/NOP/EXCEPT)
//  ir_src_dec   out  2  IR source, decode->exec
//  exc_cause    out  2  registered: 0 none, 1 illop, 2 irq (last taken)
// BEHAVIOUR
//  FSM states (registered): S_RESET, S_RUN, S_HOLD.
//  While rst=1, at the next edge: state<=S_RESET, hold_cnt<=0, exc_cause<=0.
//  S_RESET: pc_sel=RESET, pc_we=1, ir_src_if=ir_src_dec=NOP. Lasts exactly 1 cycle -> S_RUN.
//  S_RUN/S_HOLD: outputs combinational, evaluated in this priority order:
//   1 illop_dec=1 (ignores stall): pc_sel=ILLOP, pc_we=1, ir_src_dec=EXCEPT, ir_src_if=NOP.
//     Next: exc_cause<=1, hold_cnt<=IRQ_HOLDOFF, state<=S_HOLD.
//   2 irq & ~kernel_mode & ~stall & state==S_RUN: pc_sel=XADDR, pc_we=1, ir_src_dec=EXCEPT,
//     ir_src_if=NOP. Next: exc_cause<=2, hold_cnt<=IRQ_HOLDOFF, state<=S_HOLD.
//     Pre-empts any branch in decode; the branch re-executes on return (XP-4).
//   3 stall=1: pc_we=0, ir_src_if=DATA (IF holds), ir_src_dec=NOP (bubble). No redirect;
//     zr is not trusted while stalled.
//   4 taken = op_jmp | op_beq&zr | op_bne&~zr: pc_sel=JMP if op_jmp else BR, pc_we=1,
//     ir_src_if=NOP (annul fall-through fetch), ir_src_dec=DATA.
//   5 otherwise: pc_sel=INC, pc_we=1, both IR sources DATA.
//  S_HOLD: hold_cnt decrements each cycle; hold_cnt==1 -> S_RUN next. Only irq is masked;
//   illop in S_HOLD reloads hold_cnt=IRQ_HOLDOFF (stays in S_HOLD).
//  Simultaneous illop+irq: illop wins; irq stays pending (level) and is taken later.
//  rst mid-exception or mid-stall: rst wins, everything returns to S_RESET values.
//  Latency: redirect and annul take effect on the same edge as the decision (0 added cycles);
//   one taken-branch bubble, one exception bubble.
//  Illegal FSM encoding: recover to S_RESET.
// STRUCTURE
//  Add to defines.v: PC_SEL_* codes (3b), EXC_* cause codes, FSM state enum.
//  IR_SRC_* already shared. Single module; no sub-module. The holdoff counter lives inline.
// TESTING
//  rst 2 cycles -> one cycle pc_sel=5, NOP/NOP; then pc_sel=0, pc_we=1, exc_cause=0.
//  op_beq=1, zr=1, stall=0 -> pc_sel=1, ir_src_if=NOP. Same with zr=0 -> pc_sel=0, DATA/DATA.
//  stall=1, op_jmp=1 -> pc_we=0, ir_src_dec=NOP, pc_sel!=2. Stall drops -> pc_sel=2 that cycle.
//  irq=1, kernel_mode=0 -> pc_sel=4, ir_src_dec=EXCEPT, exc_cause=2. irq held -> masked 3 cycles
//   (pc_sel=0), retaken on 4th. kernel_mode=1 -> never taken.
//  illop_dec & irq same cycle, stall=1 -> pc_sel=3, exc_cause=1. illop in S_HOLD -> counter reload.
//  rst asserted while in S_HOLD -> S_RESET next cycle, hold_cnt=0, exc_cause=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the Beta pipeline sequencer: PC mux selects, IR sources,
// exception causes and the controller FSM states.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    PC_SEL_INC   = 3'd0,
    PC_SEL_BR    = 3'd1,
    PC_SEL_JMP   = 3'd2,
    PC_SEL_ILLOP = 3'd3,
    PC_SEL_XADDR = 3'd4,
    PC_SEL_RESET = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    IR_SRC_DATA   = 2'd0,
    IR_SRC_NOP    = 2'd1,
    IR_SRC_EXCEPT = 2'd2
  } ir_src_e;

  typedef enum logic [1:0] {
    EXC_NONE  = 2'd0,
    EXC_ILLOP = 2'd1,
    EXC_IRQ   = 2'd2
  } exc_e;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage Beta pipeline: PC redirect, IR annulment,
// reset sequencing and exception/interrupt injection with an irq holdoff window.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_HOLDOFF = 3,
  parameter int unsigned CNT_W       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       op_jmp,
  input  logic       op_beq,
  input  logic       op_bne,
  input  logic       zr,
  input  logic       illop_dec,
  input  logic       irq,
  input  logic       kernel_mode,
  output logic [2:0] pc_sel,
  output logic       pc_we,
  output logic [1:0] ir_src_if,
  output logic [1:0] ir_src_dec,
  output logic [1:0] exc_cause
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(IRQ_HOLDOFF);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  exc_e             cause_q, cause_d;

  pc_sel_e          pc_sel_c;
  ir_src_e          ir_if_c, ir_dec_c;
  logic             taken;

  assign taken = op_jmp | (op_beq & zr) | (op_bne & ~zr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      hold_q  <= '0;
      cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cause_d  = cause_q;
    pc_sel_c = PC_SEL_INC;
    pc_we    = 1'b1;
    ir_if_c  = IR_SRC_DATA;
    ir_dec_c = IR_SRC_DATA;

    case (state_q)
      S_RUN, S_HOLD: begin
        // Holdoff countdown is the baseline; an exception below overrides it with a reload.
        if (state_q == S_HOLD) begin
          hold_d = hold_q - 1'b1;
          if (hold_q <= CNT_W'(1)) begin
            state_d = S_RUN;
          end
        end

        if (illop_dec) begin
          pc_sel_c = PC_SEL_ILLOP;
          ir_if_c  = IR_SRC_NOP;
          ir_dec_c = IR_SRC_EXCEPT;
          cause_d  = EXC_ILLOP;
          hold_d   = HOLD_LOAD;
          state_d  = S_HOLD;
        end else if (irq && !kernel_mode && !stall && state_q == S_RUN) begin
          pc_sel_c = PC_SEL_XADDR;
          ir_if_c  = IR_SRC_NOP;
          ir_dec_c = IR_SRC_EXCEPT;
          cause_d  = EXC_IRQ;
          hold_d   = HOLD_LOAD;
          state_d  = S_HOLD;
        end else if (stall) begin
          pc_we    = 1'b0;
          ir_dec_c = IR_SRC_NOP;
        end else if (taken) begin
          pc_sel_c = op_jmp ? PC_SEL_JMP : PC_SEL_BR;
          ir_if_c  = IR_SRC_NOP;
        end
      end

      default: begin
        // S_RESET and any unused encoding both take the reset vector.
        pc_sel_c = PC_SEL_RESET;
        ir_if_c  = IR_SRC_NOP;
        ir_dec_c = IR_SRC_NOP;
        hold_d   = '0;
        state_d  = (state_q == S_RESET) ? S_RUN : S_RESET;
      end
    endcase
  end

  assign pc_sel     = pc_sel_c;
  assign ir_src_if  = ir_if_c;
  assign ir_src_dec = ir_dec_c;
  assign exc_cause  = cause_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-level reference model.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst, stall, op_jmp, op_beq, op_bne, zr, illop_dec, irq, kernel_mode;
  logic [2:0] pc_sel;
  logic       pc_we;
  logic [1:0] ir_src_if, ir_src_dec, exc_cause;

  int checks = 0;
  int errors = 0;

  // Reference model state: reset-vector pending, remaining irq-masked cycles, last cause.
  bit m_in_reset = 1'b1;
  int m_hold     = 0;
  int m_cause    = 0;

  // Expected outputs for the current inputs; e_sel < 0 means pc_sel is don't-care.
  int e_sel, e_we, e_if, e_dec;

  always #5 clk = ~clk;

  pipeline_ctrl #(.IRQ_HOLDOFF(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op_jmp(op_jmp), .op_beq(op_beq),
    .op_bne(op_bne), .zr(zr), .illop_dec(illop_dec), .irq(irq),
    .kernel_mode(kernel_mode), .pc_sel(pc_sel), .pc_we(pc_we),
    .ir_src_if(ir_src_if), .ir_src_dec(ir_src_dec), .exc_cause(exc_cause)
  );

  function automatic bit irq_taken_now();
    return irq && !kernel_mode && !stall && m_hold == 0 && !illop_dec;
  endfunction

  task automatic compute_expect();
    if (m_in_reset) begin
      e_sel = 5; e_we = 1; e_if = 1; e_dec = 1;
    end else if (illop_dec) begin
      e_sel = 3; e_we = 1; e_if = 1; e_dec = 2;
    end else if (irq_taken_now()) begin
      e_sel = 4; e_we = 1; e_if = 1; e_dec = 2;
    end else if (stall) begin
      e_sel = -1; e_we = 0; e_if = 0; e_dec = 1;
    end else if (op_jmp) begin
      e_sel = 2; e_we = 1; e_if = 1; e_dec = 0;
    end else if ((op_beq && zr) || (op_bne && !zr)) begin
      e_sel = 1; e_we = 1; e_if = 1; e_dec = 0;
    end else begin
      e_sel = 0; e_we = 1; e_if = 0; e_dec = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_in_reset = 1'b1; m_hold = 0; m_cause = 0;
    end else if (m_in_reset) begin
      m_in_reset = 1'b0;
    end else if (illop_dec) begin
      m_cause = 1; m_hold = 3;
    end else if (irq_taken_now()) begin
      m_cause = 2; m_hold = 3;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
    #1;
  endtask

  task automatic set_in(input bit s, input bit j, input bit bq, input bit bn, input bit z,
                        input bit il, input bit iq, input bit km);
    stall = s; op_jmp = j; op_beq = bq; op_bne = bn; zr = z;
    illop_dec = il; irq = iq; kernel_mode = km;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (pc_sel !== 3'd5)     begin errors++; $display("FAIL reset_pc_sel: got %0d expected 5", pc_sel); end
    if (pc_we !== 1'b1)      begin errors++; $display("FAIL reset_pc_we: got %0d expected 1", pc_we); end
    if (ir_src_if !== 2'd1 || ir_src_dec !== 2'd1)
      begin errors++; $display("FAIL reset_ir_src: got %0d/%0d expected 1/1", ir_src_if, ir_src_dec); end
    if (exc_cause !== 2'd0)  begin errors++; $display("FAIL reset_exc_cause: got %0d expected 0", exc_cause); end
    tick();
    @(negedge clk);
    checks += 3;
    if (pc_sel !== 3'd0)     begin errors++; $display("FAIL post_reset_pc_sel: got %0d expected 0", pc_sel); end
    if (pc_we !== 1'b1)      begin errors++; $display("FAIL post_reset_pc_we: got %0d expected 1", pc_we); end
    if (exc_cause !== 2'd0)  begin errors++; $display("FAIL post_reset_exc_cause: got %0d expected 0", exc_cause); end
    tick();
  endtask

  task automatic test_branch();
    // {jmp, beq, bne, zr} -> {pc_sel, ir_src_if, ir_src_dec}
    logic [3:0] vec [5] = '{4'b0101, 4'b0100, 4'b0010, 4'b0011, 4'b1000};
    int         sel [5] = '{1, 0, 1, 0, 2};
    int         sif [5] = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      set_in(0, vec[i][3], vec[i][2], vec[i][1], vec[i][0], 0, 0, 0);
      @(negedge clk);
      checks += 3;
      if (pc_sel !== 3'(sel[i]))
        begin errors++; $display("FAIL branch_pc_sel[%0d]: got %0d expected %0d", i, pc_sel, sel[i]); end
      if (ir_src_if !== 2'(sif[i]))
        begin errors++; $display("FAIL branch_ir_src_if[%0d]: got %0d expected %0d", i, ir_src_if, sif[i]); end
      if (ir_src_dec !== 2'd0 || pc_we !== 1'b1)
        begin errors++; $display("FAIL branch_dec_we[%0d]: got %0d/%0d expected 0/1", i, ir_src_dec, pc_we); end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks += 3;
      if (pc_we !== 1'b0)      begin errors++; $display("FAIL stall_pc_we: got %0d expected 0", pc_we); end
      if (ir_src_dec !== 2'd1 || ir_src_if !== 2'd0)
        begin errors++; $display("FAIL stall_ir_src: got %0d/%0d expected 0/1", ir_src_if, ir_src_dec); end
      if (pc_sel === 3'd2)     begin errors++; $display("FAIL stall_no_redirect: got %0d expected not 2", pc_sel); end
      tick();
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (pc_sel !== 3'd2)     begin errors++; $display("FAIL unstall_jmp: got %0d expected 2", pc_sel); end
    if (pc_we !== 1'b1)      begin errors++; $display("FAIL unstall_pc_we: got %0d expected 1", pc_we); end
    tick();
  endtask

  task automatic test_irq();
    set_in(0, 0, 1, 0, 1, 0, 1, 0);
    @(negedge clk);
    checks += 2;
    if (pc_sel !== 3'd4)     begin errors++; $display("FAIL irq_pc_sel: got %0d expected 4", pc_sel); end
    if (ir_src_dec !== 2'd2) begin errors++; $display("FAIL irq_ir_src_dec: got %0d expected 2", ir_src_dec); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (exc_cause !== 2'd2) begin errors++; $display("FAIL irq_exc_cause[%0d]: got %0d expected 2", i, exc_cause); end
      if (pc_sel !== 3'd0)    begin errors++; $display("FAIL irq_masked[%0d]: got %0d expected 0", i, pc_sel); end
      tick();
    end
    @(negedge clk);
    checks++;
    if (pc_sel !== 3'd4)     begin errors++; $display("FAIL irq_retaken: got %0d expected 4", pc_sel); end
    tick();
    kernel_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (pc_sel === 3'd4)   begin errors++; $display("FAIL irq_kernel_masked[%0d]: got %0d expected not 4", i, pc_sel); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_illop();
    set_in(1, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    checks += 2;
    if (pc_sel !== 3'd3)     begin errors++; $display("FAIL illop_pc_sel: got %0d expected 3", pc_sel); end
    if (pc_we !== 1'b1 || ir_src_dec !== 2'd2)
      begin errors++; $display("FAIL illop_we_dec: got %0d/%0d expected 1/2", pc_we, ir_src_dec); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checks += 2;
    if (exc_cause !== 2'd1)  begin errors++; $display("FAIL illop_exc_cause: got %0d expected 1", exc_cause); end
    if (pc_sel !== 3'd0)     begin errors++; $display("FAIL illop_irq_masked: got %0d expected 0", pc_sel); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    checks++;
    if (pc_sel !== 3'd3)     begin errors++; $display("FAIL illop_in_hold: got %0d expected 3", pc_sel); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pc_sel !== 3'd0)   begin errors++; $display("FAIL illop_reload_masked[%0d]: got %0d expected 0", i, pc_sel); end
      tick();
    end
    @(negedge clk);
    checks++;
    if (pc_sel !== 3'd4)     begin errors++; $display("FAIL illop_reload_expiry: got %0d expected 4", pc_sel); end
    tick();
  endtask

  task automatic test_rst_mid();
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    illop_dec = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (pc_sel !== 3'd5)     begin errors++; $display("FAIL rst_mid_pc_sel: got %0d expected 5", pc_sel); end
    if (exc_cause !== 2'd0)  begin errors++; $display("FAIL rst_mid_exc_cause: got %0d expected 0", exc_cause); end
    tick();
    @(negedge clk);
    checks++;
    if (pc_sel !== 3'd4)     begin errors++; $display("FAIL rst_mid_hold_cleared: got %0d expected 4", pc_sel); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      set_in($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(2) == 0,
             $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom_range(11) == 0,
             $urandom_range(2) == 0, $urandom_range(3) == 0);
      @(negedge clk);
      compute_expect();
      checks += 5;
      if (e_sel >= 0 && pc_sel !== 3'(e_sel))
        begin errors++; $display("FAIL rand_pc_sel[%0d]: got %0d expected %0d", i, pc_sel, e_sel); end
      if (e_sel < 0 && pc_sel === 3'd2)
        begin errors++; $display("FAIL rand_stall_redirect[%0d]: got %0d expected not 2", i, pc_sel); end
      if (pc_we !== 1'(e_we))
        begin errors++; $display("FAIL rand_pc_we[%0d]: got %0d expected %0d", i, pc_we, e_we); end
      if (ir_src_if !== 2'(e_if))
        begin errors++; $display("FAIL rand_ir_src_if[%0d]: got %0d expected %0d", i, ir_src_if, e_if); end
      if (ir_src_dec !== 2'(e_dec))
        begin errors++; $display("FAIL rand_ir_src_dec[%0d]: got %0d expected %0d", i, ir_src_dec, e_dec); end
      if (exc_cause !== 2'(m_cause))
        begin errors++; $display("FAIL rand_exc_cause[%0d]: got %0d expected %0d", i, exc_cause, m_cause); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_branch();
    test_stall();
    test_irq();
    test_illop();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
